// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Covers data/address widths, the FSM state encoding and the requester ids.
package reg_write_arbiter_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LD  = 1'b1;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Writeback request/handshake bundle plus the reg_file write-side outputs.
// The master side is the CPU writeback sources; the slave side is the arbiter.
interface reg_write_arbiter_if;
  import reg_write_arbiter_pkg::*;

  logic  CLEAR_REQ;
  logic  CLEAR_BUSY;

  logic  REQ0_VALID;
  addr_t REQ0_ADDR;
  data_t REQ0_DATA;
  logic  REQ0_READY;

  logic  REQ1_VALID;
  addr_t REQ1_ADDR;
  data_t REQ1_DATA;
  logic  REQ1_READY;

  logic  WRITE;
  addr_t INADDRESS;
  data_t IN;
  logic  GRANT_ID;

  modport master (
    output CLEAR_REQ,
    output REQ0_VALID, REQ0_ADDR, REQ0_DATA,
    output REQ1_VALID, REQ1_ADDR, REQ1_DATA,
    input  CLEAR_BUSY, REQ0_READY, REQ1_READY,
    input  WRITE, INADDRESS, IN, GRANT_ID
  );

  modport slave (
    input  CLEAR_REQ,
    input  REQ0_VALID, REQ0_ADDR, REQ0_DATA,
    input  REQ1_VALID, REQ1_ADDR, REQ1_DATA,
    output CLEAR_BUSY, REQ0_READY, REQ1_READY,
    output WRITE, INADDRESS, IN, GRANT_ID
  );

endinterface

// File: rtl/reg_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone valid wins, a tie goes to the requester
// that did not win last time. Purely combinational, one-hot (or zero) grant.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: default first so every path assigns grant and no latch is inferred.
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the reg_file write port between ALU writeback (0) and load/debug
// return (1), and runs a CLEAR sweep that writes zero to every register.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  reg_write_arbiter_if.slave  bus
);

  state_t     state;
  addr_t      sweep_cnt;
  logic       last;
  logic [1:0] grant;
  logic       accept_en;

  rr_arbiter2 u_rr (
    .valid ({bus.REQ1_VALID, bus.REQ0_VALID}),
    .last  (last),
    .grant (grant)
  );

  // CLEAR_REQ pre-empts arbitration in the same cycle it is seen.
  assign accept_en      = (state == ST_IDLE) && !bus.CLEAR_REQ;
  assign bus.REQ0_READY = accept_en & grant[0];
  assign bus.REQ1_READY = accept_en & grant[1];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= ST_IDLE;
      sweep_cnt      <= '0;
      last           <= REQ_LD;
      bus.WRITE      <= 1'b0;
      bus.INADDRESS  <= '0;
      bus.IN         <= '0;
      bus.GRANT_ID   <= REQ_ALU;
      bus.CLEAR_BUSY <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.CLEAR_REQ) begin
            state          <= ST_CLEAR;
            bus.WRITE      <= 1'b1;
            bus.INADDRESS  <= sweep_cnt;
            bus.IN         <= '0;
            bus.GRANT_ID   <= REQ_ALU;
            bus.CLEAR_BUSY <= 1'b1;
            sweep_cnt      <= sweep_cnt + 1'b1;
          end else if (grant != 2'b00) begin
            bus.WRITE     <= 1'b1;
            bus.INADDRESS <= grant[1] ? bus.REQ1_ADDR : bus.REQ0_ADDR;
            bus.IN        <= grant[1] ? bus.REQ1_DATA : bus.REQ0_DATA;
            bus.GRANT_ID  <= grant[1] ? REQ_LD : REQ_ALU;
            last          <= grant[1] ? REQ_LD : REQ_ALU;
          end else begin
            bus.WRITE <= 1'b0;
          end
        end

        ST_CLEAR: begin
          // During a sweep INADDRESS always holds the last address issued.
          if (bus.INADDRESS == addr_t'(NUM_REGS - 1)) begin
            state          <= ST_IDLE;
            bus.WRITE      <= 1'b0;
            bus.CLEAR_BUSY <= 1'b0;
          end else begin
            bus.WRITE     <= 1'b1;
            bus.INADDRESS <= sweep_cnt;
            bus.IN        <= '0;
            bus.GRANT_ID  <= REQ_ALU;
            sweep_cnt     <= sweep_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios followed by
// random traffic, compared cycle by cycle against a behavioural model.
module tb_reg_write_arbiter;
  import reg_write_arbiter_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  reg_write_arbiter_if bus ();

  reg_write_arbiter dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  // Stand-in for reg_file: commits whatever the arbiter writes.
  logic [7:0] rf [8] = '{default: 8'h00};
  always @(posedge CLK) if (bus.WRITE === 1'b1) rf[bus.INADDRESS] <= bus.IN;

  int n_cmp = 0;
  int n_err = 0;

  // Requester stimulus
  logic       clr, v0, v1;
  logic [2:0] a0, a1;
  logic [7:0] d0, d1;
  bit         acc0, acc1;
  logic       obs_r0, obs_r1;

  // Behavioural model
  logic       m_write, m_busy, m_gid;
  logic [2:0] m_addr;
  logic [7:0] m_data;
  int         m_last;
  int         clr_q[$];
  logic [7:0] exp_rf [8] = '{default: 8'h00};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_write = 1'b0; m_addr = '0; m_data = '0; m_gid = 1'b0;
    m_busy  = 1'b0; m_last = 1;
    clr_q.delete();
  endtask

  // One clock cycle: drive, check this cycle's outputs, advance the model.
  task automatic step();
    logic e_r0, e_r1;
    bus.CLEAR_REQ  = clr;
    bus.REQ0_VALID = v0; bus.REQ0_ADDR = a0; bus.REQ0_DATA = d0;
    bus.REQ1_VALID = v1; bus.REQ1_ADDR = a1; bus.REQ1_DATA = d1;
    #1;
    e_r0 = 1'b0; e_r1 = 1'b0;
    if (!m_busy && !clr) begin
      if (v0 && v1) begin
        e_r0 = (m_last != 0);
        e_r1 = (m_last == 0);
      end else begin
        e_r0 = v0;
        e_r1 = v1;
      end
    end
    obs_r0 = bus.REQ0_READY;
    obs_r1 = bus.REQ1_READY;
    check("WRITE", bus.WRITE, m_write);
    check("INADDRESS", bus.INADDRESS, m_addr);
    check("IN", bus.IN, m_data);
    check("GRANT_ID", bus.GRANT_ID, m_gid);
    check("CLEAR_BUSY", bus.CLEAR_BUSY, m_busy);
    check("REQ0_READY", obs_r0, e_r0);
    check("REQ1_READY", obs_r1, e_r1);
    acc0 = e_r0;
    acc1 = e_r1;

    if (m_write) exp_rf[m_addr] = m_data;
    if (RESET) begin
      model_reset();
    end else if (m_busy) begin
      if (clr_q.size() > 0) begin
        m_addr = 3'(clr_q.pop_front()); m_data = '0; m_gid = 1'b0; m_write = 1'b1;
      end else begin
        m_busy = 1'b0; m_write = 1'b0;
      end
    end else if (clr) begin
      clr_q.delete();
      for (int k = 0; k < 8; k++) clr_q.push_back(k);
      m_addr = 3'(clr_q.pop_front()); m_data = '0; m_gid = 1'b0;
      m_write = 1'b1; m_busy = 1'b1;
    end else if (e_r0 || e_r1) begin
      m_write = 1'b1;
      m_gid   = e_r1;
      m_addr  = e_r1 ? a1 : a0;
      m_data  = e_r1 ? d1 : d0;
      m_last  = e_r1 ? 1 : 0;
    end else begin
      m_write = 1'b0;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bit got;
    int waited;
    RESET = 1'b1; clr = 1'b0; v0 = 1'b0; v1 = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    model_reset();
    @(posedge CLK);
    #1;
    step();
    RESET = 1'b0;
    step();
    step();

    // Tie for 4 cycles: grants alternate starting with requester 0.
    v0 = 1'b1; a0 = 3'd1; d0 = 8'h11;
    v1 = 1'b1; a1 = 3'd2; d1 = 8'h22;
    for (int i = 0; i < 4; i++) begin
      step();
      check("tie_grant_r0", obs_r0, (i % 2 == 0));
      if (acc0) d0++;
      if (acc1) d1++;
    end
    v0 = 1'b0; v1 = 1'b0;
    step();

    // Requester 0 alone.
    v0 = 1'b1; a0 = 3'd3; d0 = 8'h5A;
    step();
    v0 = 1'b0;
    step();
    step();
    check("reg3", rf[3], 8'h5A);

    // Preload 1..8, then a one-cycle CLEAR pulse.
    for (int i = 0; i < 8; i++) begin
      v1 = 1'b1; a1 = 3'(i); d1 = 8'(i + 1);
      step();
    end
    v1 = 1'b0;
    step();
    check("preload_reg7", rf[7], 8'h08);
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 9; i++) step();
    for (int i = 0; i < 8; i++) check("cleared_reg", rf[i], 8'h00);

    // CLEAR and a load return arrive together: load waits out the sweep.
    clr = 1'b1; v1 = 1'b1; a1 = 3'd5; d1 = 8'h77;
    step();
    clr = 1'b0;
    got = 1'b0; waited = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (acc1) begin
        got = 1'b1; v1 = 1'b0;
      end else begin
        waited++;
      end
    end
    check("ld_granted", got, 1);
    check("ld_wait_cycles", waited, 8);
    step();
    step();
    check("reg5", rf[5], 8'h77);

    // Reset during the sweep at k=3.
    for (int i = 0; i < 8; i++) begin
      v0 = 1'b1; a0 = 3'(i); d0 = 8'(i + 1);
      step();
    end
    v0 = 1'b0;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    step();
    for (int i = 0; i < 4; i++) check("abort_cleared", rf[i], 8'h00);
    for (int i = 4; i < 8; i++) check("abort_kept", rf[i], 8'(i + 1));
    v0 = 1'b1; a0 = 3'd6; d0 = 8'hAA;
    v1 = 1'b1; a1 = 3'd7; d1 = 8'hBB;
    step();
    check("post_reset_tie_r0", obs_r0, 1'b1);
    v0 = 1'b0;
    step();
    v1 = 1'b0;
    step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (!v0 && ($urandom % 3 == 0)) begin
        v0 = 1'b1; a0 = 3'($urandom); d0 = 8'($urandom);
      end
      if (!v1 && ($urandom % 3 == 0)) begin
        v1 = 1'b1; a1 = 3'($urandom); d1 = 8'($urandom);
      end
      clr   = ($urandom % 40 == 0);
      RESET = ($urandom % 150 == 0);
      step();
      if (acc0) v0 = 1'b0;
      if (acc1) v1 = 1'b0;
    end
    RESET = 1'b0; clr = 1'b0; v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 12; i++) step();
    for (int i = 0; i < 8; i++) check("final_reg", rf[i], exp_rf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Shares the single write port (WRITE, INADDRESS, IN) of the 8x8 register file between two writeback requesters. Requester 0 is ALU writeback and requester 1 is the load/debug return. Also runs a CLEAR sequence that writes zero to all eight registers without asserting the register file's RESET. Sits between the CPU writeback sources and reg_file; its outputs connect directly to reg_file's write-side inputs.

Parameters:
DATA_W, 8, register data width
ADDR_W, 3, register address width
NUM_REGS, 8, registers swept by CLEAR (equals 2**ADDR_W)

Ports:
CLK  input  1  system clock, all state updates on posedge
RESET  input  1  synchronous, active-high reset
CLEAR_REQ  input  1  pulse/level request to zero all registers
CLEAR_BUSY  output  1  high while the CLEAR sweep is in progress
REQ0_VALID  input  1  requester 0 has a write pending
REQ0_ADDR  input  ADDR_W  requester 0 destination register
REQ0_DATA  input  DATA_W  requester 0 write data
REQ0_READY  output  1  requester 0 accepted this cycle
REQ1_VALID / REQ1_ADDR / REQ1_DATA / REQ1_READY  same as requester 0, for requester 1
WRITE  output  1  to reg_file WRITE
INADDRESS  output  ADDR_W  to reg_file INADDRESS
IN  output  DATA_W  to reg_file IN
GRANT_ID  output  1  requester that owns the current WRITE (0/1), 0 during CLEAR

Behaviour:
- Reset: on posedge CLK with RESET=1, state goes to IDLE. WRITE=0, INADDRESS=0, IN=0, GRANT_ID=0, CLEAR_BUSY=0, sweep counter=0, round-robin pointer LAST=1, so requester 0 wins the first tie. RESET overrides everything, including a CLEAR in progress.
- Handshake: a transfer occurs when VALID and READY are both high at a posedge. Requesters hold VALID, ADDR and DATA stable until READY. READYi is combinational from state, CLEAR_REQ and both VALIDs.
- Arbitration (IDLE, CLEAR_REQ=0):
  - only one VALID: that requester gets READY.
  - both VALID: the requester not equal to LAST gets READY.
  - LAST updates to the granted id on each transfer.
  - At most one READY is high per cycle.
- Latency: the output stage is registered. A transfer at edge N drives WRITE=1 with that request's ADDR, DATA and id during cycle N+1; reg_file commits at edge N+1. Back-to-back transfers give a 1 write/cycle throughput. With no transfer at edge N, WRITE=0 in cycle N+1; INADDRESS and IN hold their last values.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when CLEAR_REQ=1 at a posedge. CLEAR has priority, so both READYs are low in that cycle.
  - CLEAR: for sweep counter k=0..NUM_REGS-1, drive WRITE=1, INADDRESS=k, IN=0, GRANT_ID=0. This takes 8 consecutive cycles starting the cycle after entry.
  - CLEAR_BUSY=1 during exactly those 8 cycles. Both READYs stay 0.
  - CLEAR -> IDLE after the k=7 write is issued; the counter wraps to 0.
  - CLEAR_REQ is ignored while in CLEAR. If CLEAR_REQ is still high on return to IDLE, a new sweep starts.
- A pending VALID during CLEAR waits; it is granted on the first IDLE cycle using normal round-robin.
- Same-address writes from both requesters are serialized in grant order; the last write wins.
- RESET mid-CLEAR: the sweep aborts and the registers already cleared stay cleared.
- Widths: ADDR and DATA pass through unmodified; no arithmetic beyond the ADDR_W-bit sweep counter.

Decomposition:
- Shared package: DATA_W/ADDR_W/NUM_REGS constants, the state encoding (IDLE=0, CLEAR=1), and requester id constants (REQ_ALU=0, REQ_LD=1).
- One natural sub-module: rr_arbiter2. It takes two valids and LAST and produces one-hot grants, and is reusable for the later memory-port arbiter.
- The FSM, sweep counter and output register stay in the top.

Test Plan:
- RESET=1 for 2 cycles -> WRITE=0, INADDRESS=0, IN=0, CLEAR_BUSY=0, READY0=READY1=0 until a VALID is presented.
- REQ0 only: addr=3, data=8'h5A -> READY0 same cycle; next cycle WRITE=1, INADDRESS=3, IN=8'h5A, GRANT_ID=0; reg3 reads 8'h5A afterwards.
- Both valid continuously for 4 cycles (REQ0 addr1/data 11, REQ1 addr2/data 22, new data each accept) -> grants alternate 0,1,0,1 starting with 0; WRITE high 4 consecutive cycles.
- Preload reg0..7 with 1..8, pulse CLEAR_REQ one cycle -> CLEAR_BUSY high 8 cycles, INADDRESS 0..7 with IN=0; all registers read 0 afterwards.
- CLEAR_REQ at the same edge as REQ1_VALID (addr 5, data 8'h77) -> REQ1_READY=0 during the sweep; REQ1 is granted the first cycle after CLEAR_BUSY falls, and reg5=8'h77 at the end.
- RESET asserted at sweep k=3 -> next cycle WRITE=0, CLEAR_BUSY=0, state IDLE; regs 0..3 zero, regs 4..7 keep their preloaded values. A subsequent tie grants requester 0.
